// File: rtl/imem_line_cache_if.sv
// imem_line_cache_if: word-addressed main-memory port 1 between the cache (master) and memory (slave)
interface imem_line_cache_if;
  logic        MEM_RDEN1;
  logic [13:0] MEM_ADDR1;
  logic [31:0] MEM_DOUT1;
  logic        MEM_VALID1;
  modport master (output MEM_RDEN1, MEM_ADDR1, input MEM_DOUT1, MEM_VALID1);
  modport slave  (input MEM_RDEN1, MEM_ADDR1, output MEM_DOUT1, MEM_VALID1);
endinterface

// File: rtl/imem_line_cache.sv
// imem_line_cache: direct-mapped instruction cache with combinational hits and in-order line refill
module imem_line_cache #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int CNT_W          = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [31:0]         PC,
  input  logic                CPU_RDEN,
  input  logic                FLUSH,
  output logic [31:0]         INSTR,
  output logic                HIT,
  output logic                STALL,
  imem_line_cache_if.master   mem,
  output logic [CNT_W-1:0]    MISS_COUNT
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = 14 - OW - IW;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [13:0]   wa;
  logic [OW-1:0] off, cnt;
  logic [IW-1:0] idx, fill_idx;
  logic [TW-1:0] tag, fill_tag;
  logic [31:0]   data [LINES*WORDS_PER_LINE];
  logic [TW-1:0] tags [LINES];
  logic [LINES-1:0] valid;
  logic lookup, miss, acc, last, v_q, rden;
  logic unused_pc;
  assign unused_pc = ^{PC[31:16], PC[1:0]};
  assign wa  = PC[15:2];
  assign off = wa[OW-1:0];
  assign idx = wa[OW+IW-1:OW];
  assign tag = wa[13:OW+IW];
  assign lookup = valid[idx] && (tags[idx] == tag);
  assign mem.MEM_RDEN1 = rden;
  assign mem.MEM_ADDR1 = {fill_tag, fill_idx, cnt};
  always_comb begin
    state_n = state;
    HIT     = 1'b0;
    STALL   = 1'b0;
    miss    = 1'b0;
    acc     = 1'b0;
    last    = 1'b0;
    if (state == IDLE) begin
      HIT     = CPU_RDEN & lookup;
      STALL   = CPU_RDEN & ~lookup;
      miss    = CPU_RDEN & ~lookup;
      state_n = miss ? FILL : IDLE;
    end else begin
      STALL   = 1'b1;
      acc     = mem.MEM_VALID1 & ~v_q;
      last    = acc & (&cnt);
      state_n = last ? IDLE : FILL;
    end
    INSTR = HIT ? data[{idx, off}] : NOP;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      valid      <= '0;
      cnt        <= '0;
      MISS_COUNT <= '0;
      rden       <= 1'b0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      v_q        <= 1'b0;
    end else begin
      state <= state_n;
      v_q   <= mem.MEM_VALID1;
      if (miss) begin
        fill_tag <= tag;
        fill_idx <= idx;
        cnt      <= '0;
        rden     <= 1'b1;
        if (!(&MISS_COUNT)) MISS_COUNT <= MISS_COUNT + CNT_W'(1);
      end
      if (acc) cnt <= cnt + OW'(1);
      if (last) rden <= 1'b0;
      // a flush coinciding with the last accept still leaves the just-filled line valid
      if (FLUSH) valid <= '0;
      if (last) valid[fill_idx] <= 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (acc) data[{fill_idx, cnt}] <= mem.MEM_DOUT1;
    if (last) tags[fill_idx] <= fill_tag;
  end
endmodule

// File: tb/tb_imem_line_cache.sv
// tb_imem_line_cache: scoreboard bench with a strobing memory model and directed fetch scenarios
module tb_imem_line_cache;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic cpu_rden = 1'b0, flush = 1'b0;
  logic [31:0] instr;
  logic hit, stall;
  logic [15:0] miss_count;
  imem_line_cache_if mif();
  imem_line_cache dut (
    .CLK(clk), .RST_N(rst_n), .PC(pc), .CPU_RDEN(cpu_rden), .FLUSH(flush),
    .INSTR(instr), .HIT(hit), .STALL(stall), .mem(mif.master), .MISS_COUNT(miss_count)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit auto_mem = 1'b1;
  int lim = 1000000;
  logic pv = 1'b0;
  logic [31:0] exp_instr[$];
  logic [13:0] exp_addr[$];
  function automatic logic [31:0] memf(input logic [13:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    mif.MEM_DOUT1 = '0;
    mif.MEM_VALID1 = 1'b0;
  end
  // memory model: one-cycle valid pulses separated by a low cycle while read-enabled
  always begin
    @(posedge clk);
    #1;
    if (auto_mem) begin
      if (mif.MEM_RDEN1 && !mif.MEM_VALID1 && lim > 0) begin
        mif.MEM_DOUT1 = memf(mif.MEM_ADDR1);
        mif.MEM_VALID1 = 1'b1;
        lim--;
      end else mif.MEM_VALID1 = 1'b0;
    end
  end
  always @(negedge clk) begin
    if (hit) begin
      if (exp_instr.size() == 0) chk("unexpected_hit", instr, 32'hxxxxxxxx);
      else chk("hit_instr", instr, exp_instr.pop_front());
    end
    if (mif.MEM_RDEN1 && mif.MEM_VALID1 && !pv) begin
      if (exp_addr.size() == 0) chk("unexpected_fill", {18'd0, mif.MEM_ADDR1}, 32'hxxxxxxxx);
      else chk("fill_addr", {18'd0, mif.MEM_ADDR1}, {18'd0, exp_addr.pop_front()});
    end
    pv = mif.MEM_VALID1;
  end
  task automatic fetch(input logic [31:0] p, input bit miss, input int mc);
    bit got = 1'b0;
    if (miss) for (int i = 0; i < 8; i++) exp_addr.push_back(p[15:2] - 14'(p[4:2]) + 14'(i));
    exp_instr.push_back(memf(p[15:2]));
    pc = p;
    cpu_rden = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (i == 0 && miss) chk("miss_stall", {31'd0, stall}, 32'd1);
      if (hit) got = 1'b1;
    end
    chk("fetch_done", {31'd0, got}, 32'd1);
    if (!miss) begin
      chk("hit_nostall", {31'd0, stall}, 32'd0);
      chk("hit_no_rden", {31'd0, mif.MEM_RDEN1}, 32'd0);
    end
    chk("miss_count", {16'd0, miss_count}, mc);
    @(posedge clk);
    #1 cpu_rden = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    cpu_rden = 1'b1;
    pc = 32'h100;
    #12;
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_rden", {31'd0, mif.MEM_RDEN1}, 32'd0);
    chk("rst_addr", {18'd0, mif.MEM_ADDR1}, 32'd0);
    chk("rst_mc", {16'd0, miss_count}, 32'd0);
    cpu_rden = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(32'h100, 1, 1);
    fetch(32'h11C, 0, 1);
    fetch(32'h300, 1, 2);
    fetch(32'h300, 0, 2);
    fetch(32'h100, 1, 3);
    fork
      fetch(32'h040, 1, 4);
      begin
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join
    fetch(32'h044, 0, 4);
    fetch(32'h100, 1, 5);
    auto_mem = 1'b0;
    fork
      fetch(32'h060, 1, 6);
      begin
        repeat (2) @(posedge clk);
        #1;
        mif.MEM_DOUT1 = memf(14'h18);
        mif.MEM_VALID1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 mif.MEM_VALID1 = 1'b0;
        chk("t4_one_accept", {18'd0, mif.MEM_ADDR1}, 32'h19);
        auto_mem = 1'b1;
      end
    join
    lim = 3;
    for (int i = 0; i < 3; i++) exp_addr.push_back(14'h20 + 14'(i));
    pc = 32'h080;
    cpu_rden = 1'b1;
    for (int i = 0; i < 100 && mif.MEM_ADDR1 !== 14'h23; i++) @(negedge clk);
    chk("t6_reach_cnt3", {18'd0, mif.MEM_ADDR1}, 32'h23);
    chk("t6_rden_before", {31'd0, mif.MEM_RDEN1}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rden_async", {31'd0, mif.MEM_RDEN1}, 32'd0);
    chk("t6_addr_async", {18'd0, mif.MEM_ADDR1}, 32'd0);
    chk("t6_mc_async", {16'd0, miss_count}, 32'd0);
    cpu_rden = 1'b0;
    lim = 1000000;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(32'h080, 1, 1);
    fetch(32'h084, 0, 1);
    repeat (2) @(negedge clk);
    chk("exp_instr_left", exp_instr.size(), 32'd0);
    chk("exp_addr_left", exp_addr.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
